id_ex_stage_reg: RTL and testbench
==================================

# id_ex_stage_reg

ID/EX pipeline register of the 32-bit processor: captures the decoder's control bundle, opcode, operands, immediate and destination register every cycle and presents them to the execute stage. It supports stall (hold), flush (NOP bubble injection) and a branch-squash state machine that bubbles a fixed number of cycles after a PC redirect. It also holds the ALU comparison flags, and drives the EX-stage opcode and flags back to the control unit (`OpCodeIDEXOUT`, `Flags`).

## Interface
- `DATA_W`, 32, width of operand and immediate paths
- `SQUASH_N`, 2, bubbles injected per redirect (legal range 1..7)
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `stall_i`  in  1  hold all registered contents
- `flush_i`  in  1  load one bubble
- `redirect_i`  in  1  PC redirected (jump or taken branch); start squash
- `ctrl_i`  in  17  decoder bundle: [16:15] MuxDireccionPC, [14] MuxSelDirRegB, [13] crtlMuxValA, [12] crtlMuxValB, [11:8] CodigoALU, [7:6] MuxResult, [5] MuxDirWrite, [4] MuxDirMem, [3] MuxDato, [2] WriteMem, [1] WriteReg, [0] aluMux
- `opcode_i`  in  5  decoded opcode
- `opa_i`, `opb_i`, `imm_i`  in  DATA_W  operand A, operand B, immediate
- `rd_i`  in  5  destination register address
- `alu_flags_i`  in  2  EX-stage ALU flags ({gt, eq})
- `ctrl_o`  out  17  registered bundle, same packing
- `OpCodeIDEXOUT`  out  5  registered opcode
- `opa_o`, `opb_o`, `imm_o`  out  DATA_W  registered data
- `rd_o`  out  5  registered destination
- `Flags`  out  2  flags presented to the control unit
- `squashing_o`  out  1  high while in SQUASH

## Operation
- Bubble: `ctrl` = 17'h000F8, opcode = 5'b10111 (NOP), data and `rd` = 0. No memory or register write, no PC redirect.
- Load priority per edge: reset > `redirect_i` > SQUASH state > `flush_i` > `stall_i` > normal load of inputs.
- FSM states:
  - IDLE, on `redirect_i`: load bubble. If SQUASH_N > 1, go to SQUASH with cnt = SQUASH_N-1; otherwise stay in IDLE.
  - SQUASH: load bubble every cycle and ignore `stall_i`; cnt decrements. When cnt is 1 at the edge, return to IDLE.
  - `redirect_i` in SQUASH: reload cnt = SQUASH_N-1.
- cnt is 3 bits, never wraps, is never written as 0 while in SQUASH, and is reset to 0.
- Flags register `flag_q`:
  - Updates to `alu_flags_i` on an edge where `OpCodeIDEXOUT` is in {00100, 00101, 10100, 10101} and `stall_i` = 0. Otherwise it holds.
  - Flush, redirect and squash do not clear it.
- `Flags` output: combinational bypass. It equals `alu_flags_i` when `OpCodeIDEXOUT` is 10100 or 10101, otherwise `flag_q`. Branches therefore resolve on the comparison performed in the same EX cycle.
- `squashing_o` = (state == SQUASH).

## Timing
- Reset (async assert, sync-safe deassert):
  - `ctrl_o` = 17'h000F8, `OpCodeIDEXOUT` = 5'b10111.
  - data, `rd_o`, `flag_q` = 0.
  - state IDLE, cnt 0, `squashing_o` = 0.
- Latency: inputs appear on outputs 1 cycle after the capturing edge.
- Stall: outputs are unchanged for every stalled cycle; the first unstalled edge loads the current inputs.
- Flush with stall: flush wins; one bubble is loaded.
- Redirect: bubble visible the cycle after assertion. Exactly SQUASH_N consecutive bubble cycles follow a single-cycle `redirect_i` pulse.
- Reset mid-squash: immediately IDLE with bubble contents; no residual squash after release.
- `Flags` path is combinational from `alu_flags_i`/`OpCodeIDEXOUT` and adds no cycle.

## Test plan
- Reset then load: opcode 00000, ctrl 17'h002AB, opa 5, opb 7, rd 3 -> held at reset value until the edge; the cycle after, outputs match exactly.
- Stall 3 cycles while inputs change -> outputs hold the previous ADD contents for 3 cycles; the new inputs appear 1 cycle after stall drops.
- Flush with stall both high -> next cycle opcode 10111, ctrl 17'h000F8, WriteReg = WriteMem = 0.
- Redirect pulse, SQUASH_N = 2, valid inputs streaming -> exactly 2 bubble cycles and `squashing_o` high for 1 cycle; 2nd pulse mid-squash -> squash extended to 2 bubbles after that pulse.
- Compare 00100 in EX with `alu_flags_i` = 01, then branch 10101 in EX with `alu_flags_i` = 10 -> `Flags` = 10 during the branch (bypass). After the branch, `Flags` = 10 from `flag_q`; a following ADD leaves it unchanged.
- Assert `rst_n` low mid-squash for 1 cycle -> immediate bubble/IDLE, `Flags` = 00; normal loading resumes on the first edge after release.

Source files
------------

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX pipeline register bus: decoder-side inputs and execute-side registered outputs.
// The decoder/control side uses the master modport and the stage register uses the slave modport.
interface id_ex_stage_reg_if #(
  parameter int unsigned DATA_W = 32
);
  logic              stall_i;
  logic              flush_i;
  logic              redirect_i;
  logic [16:0]       ctrl_i;
  logic [4:0]        opcode_i;
  logic [DATA_W-1:0] opa_i;
  logic [DATA_W-1:0] opb_i;
  logic [DATA_W-1:0] imm_i;
  logic [4:0]        rd_i;
  logic [1:0]        alu_flags_i;

  logic [16:0]       ctrl_o;
  logic [4:0]        OpCodeIDEXOUT;
  logic [DATA_W-1:0] opa_o;
  logic [DATA_W-1:0] opb_o;
  logic [DATA_W-1:0] imm_o;
  logic [4:0]        rd_o;
  logic [1:0]        Flags;
  logic              squashing_o;

  modport master (
    output stall_i, flush_i, redirect_i, ctrl_i, opcode_i, opa_i, opb_i, imm_i, rd_i,
           alu_flags_i,
    input  ctrl_o, OpCodeIDEXOUT, opa_o, opb_o, imm_o, rd_o, Flags, squashing_o
  );

  modport slave (
    input  stall_i, flush_i, redirect_i, ctrl_i, opcode_i, opa_i, opb_i, imm_i, rd_i,
           alu_flags_i,
    output ctrl_o, OpCodeIDEXOUT, opa_o, opb_o, imm_o, rd_o, Flags, squashing_o
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with stall, flush, and a counted branch-squash FSM.
// It also keeps the compare-flag register and the same-cycle Flags bypass for branches.
module id_ex_stage_reg #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SQUASH_N = 2
) (
  input logic              clk,
  input logic              rst_n,
  id_ex_stage_reg_if.slave bus
);

  localparam logic [16:0] BubbleCtrl   = 17'h000F8;
  localparam logic [4:0]  BubbleOpcode = 5'b10111;
  localparam logic [2:0]  SquashLoad   = 3'(SQUASH_N - 1);

  typedef enum logic [0:0] {StIdle, StSquash} state_e;

  state_e            stateQ, stateD;
  logic [2:0]        cntQ, cntD;
  logic              loadBubble;

  logic [16:0]       ctrlQ, ctrlD;
  logic [4:0]        opcodeQ, opcodeD;
  logic [DATA_W-1:0] opaQ, opaD, opbQ, opbD, immQ, immD;
  logic [4:0]        rdQ, rdD;
  logic [1:0]        flagQ, flagD;
  logic              isCmpOrBranch, isBranch;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= StIdle;
      cntQ   <= 3'd0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  // FSM next state: a redirect always (re)starts the squash window
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    if (bus.redirect_i) begin
      if (SQUASH_N > 1) begin
        stateD = StSquash;
        cntD   = SquashLoad;
      end else begin
        stateD = StIdle;
        cntD   = 3'd0;
      end
    end else if (stateQ == StSquash) begin
      if (cntQ == 3'd1) begin
        stateD = StIdle;
        cntD   = 3'd0;
      end else begin
        cntD = cntQ - 3'd1;
      end
    end
  end

  // FSM outputs
  always_comb begin
    loadBubble      = bus.redirect_i || (stateQ == StSquash) || bus.flush_i;
    bus.squashing_o = (stateQ == StSquash);
  end

  // Pipeline register next state; the bubble outranks the stall
  always_comb begin
    ctrlD   = ctrlQ;
    opcodeD = opcodeQ;
    opaD    = opaQ;
    opbD    = opbQ;
    immD    = immQ;
    rdD     = rdQ;
    if (loadBubble) begin
      ctrlD   = BubbleCtrl;
      opcodeD = BubbleOpcode;
      opaD    = '0;
      opbD    = '0;
      immD    = '0;
      rdD     = '0;
    end else if (!bus.stall_i) begin
      ctrlD   = bus.ctrl_i;
      opcodeD = bus.opcode_i;
      opaD    = bus.opa_i;
      opbD    = bus.opb_i;
      immD    = bus.imm_i;
      rdD     = bus.rd_i;
    end
  end

  always_comb begin
    isBranch      = (opcodeQ == 5'b10100) || (opcodeQ == 5'b10101);
    isCmpOrBranch = isBranch || (opcodeQ == 5'b00100) || (opcodeQ == 5'b00101);
    flagD         = (isCmpOrBranch && !bus.stall_i) ? bus.alu_flags_i : flagQ;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrlQ   <= BubbleCtrl;
      opcodeQ <= BubbleOpcode;
      opaQ    <= '0;
      opbQ    <= '0;
      immQ    <= '0;
      rdQ     <= '0;
      flagQ   <= 2'b00;
    end else begin
      ctrlQ   <= ctrlD;
      opcodeQ <= opcodeD;
      opaQ    <= opaD;
      opbQ    <= opbD;
      immQ    <= immD;
      rdQ     <= rdD;
      flagQ   <= flagD;
    end
  end

  // Branches in EX resolve on this cycle's comparison rather than the stored one
  always_comb begin
    bus.ctrl_o        = ctrlQ;
    bus.OpCodeIDEXOUT = opcodeQ;
    bus.opa_o         = opaQ;
    bus.opb_o         = opbQ;
    bus.imm_o         = immQ;
    bus.rd_o          = rdQ;
    bus.Flags         = isBranch ? bus.alu_flags_i : flagQ;
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: reset, load, stall, flush, squash, flags, reset mid-squash.
module tb_id_ex_stage_reg;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  id_ex_stage_reg_if #(.DATA_W(32)) bus ();

  id_ex_stage_reg #(
    .DATA_W  (32),
    .SQUASH_N(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chkBubble(input string tag);
    chk({tag, ".op"},   64'(bus.OpCodeIDEXOUT), 64'h17);
    chk({tag, ".ctrl"}, 64'(bus.ctrl_o),        64'h000F8);
    chk({tag, ".opa"},  64'(bus.opa_o),         64'h0);
    chk({tag, ".rd"},   64'(bus.rd_o),          64'h0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.stall_i    = 1'b0;
    bus.flush_i    = 1'b0;
    bus.redirect_i = 1'b0;
    bus.ctrl_i     = 17'h002AB;
    bus.opcode_i   = 5'b00000;
    bus.opa_i      = 32'd5;
    bus.opb_i      = 32'd7;
    bus.imm_i      = 32'd0;
    bus.rd_i       = 5'd3;
    bus.alu_flags_i = 2'b00;

    // Reset state
    #12;
    chkBubble("reset");
    chk("reset.opb",   64'(bus.opb_o),       64'h0);
    chk("reset.sq",    64'(bus.squashing_o), 64'h0);
    chk("reset.flags", 64'(bus.Flags),       64'h0);
    rst_n = 1'b1;

    // First load
    step();
    chk("load.ctrl", 64'(bus.ctrl_o),        64'h002AB);
    chk("load.op",   64'(bus.OpCodeIDEXOUT), 64'h0);
    chk("load.opa",  64'(bus.opa_o),         64'd5);
    chk("load.opb",  64'(bus.opb_o),         64'd7);
    chk("load.rd",   64'(bus.rd_o),          64'd3);

    // Stall three cycles while inputs change
    bus.stall_i  = 1'b1;
    bus.opcode_i = 5'b00001;
    bus.ctrl_i   = 17'h01234;
    bus.opa_i    = 32'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.opa",  64'(bus.opa_o),  64'd5);
      chk("stall.ctrl", 64'(bus.ctrl_o), 64'h002AB);
    end
    bus.stall_i = 1'b0;
    step();
    chk("unstall.opa", 64'(bus.opa_o),         64'd9);
    chk("unstall.op",  64'(bus.OpCodeIDEXOUT), 64'h1);

    // Flush beats stall
    bus.flush_i = 1'b1;
    bus.stall_i = 1'b1;
    step();
    chkBubble("flush");
    chk("flush.wr", 64'(bus.ctrl_o[2:1]), 64'h0);
    bus.flush_i = 1'b0;
    bus.stall_i = 1'b0;

    // Single redirect pulse: two bubbles, squashing for one cycle
    bus.opcode_i   = 5'b00010;
    bus.ctrl_i     = 17'h00ABC;
    bus.opa_i      = 32'd11;
    bus.redirect_i = 1'b1;
    step();
    chkBubble("redir1.b1");
    chk("redir1.sq1", 64'(bus.squashing_o), 64'h1);
    bus.redirect_i = 1'b0;
    step();
    chkBubble("redir1.b2");
    chk("redir1.sq2", 64'(bus.squashing_o), 64'h0);
    step();
    chk("redir1.op",  64'(bus.OpCodeIDEXOUT), 64'h2);
    chk("redir1.opa", 64'(bus.opa_o),         64'd11);

    // Second pulse mid-squash extends the window
    bus.redirect_i = 1'b1;
    step();
    chkBubble("redir2.b1");
    step();
    chkBubble("redir2.b2");
    chk("redir2.sq2", 64'(bus.squashing_o), 64'h1);
    bus.redirect_i = 1'b0;
    step();
    chkBubble("redir2.b3");
    chk("redir2.sq3", 64'(bus.squashing_o), 64'h0);
    step();
    chk("redir2.op", 64'(bus.OpCodeIDEXOUT), 64'h2);

    // Compare then branch: flag register and bypass
    bus.opcode_i = 5'b00100;
    step();
    bus.alu_flags_i = 2'b01;
    #1;
    chk("cmp.flags", 64'(bus.Flags), 64'h0);
    bus.opcode_i = 5'b10101;
    step();
    bus.alu_flags_i = 2'b10;
    #1;
    chk("br.bypass", 64'(bus.Flags), 64'h2);
    bus.opcode_i = 5'b00000;
    step();
    bus.alu_flags_i = 2'b11;
    #1;
    chk("add.flags1", 64'(bus.Flags), 64'h2);
    step();
    chk("add.flags2", 64'(bus.Flags), 64'h2);

    // Reset asserted mid-squash
    bus.redirect_i = 1'b1;
    step();
    bus.redirect_i = 1'b0;
    bus.opcode_i   = 5'b00011;
    bus.opa_i      = 32'd22;
    chk("pre.sq", 64'(bus.squashing_o), 64'h1);
    rst_n = 1'b0;
    #1;
    chkBubble("rst.mid");
    chk("rst.sq",    64'(bus.squashing_o), 64'h0);
    chk("rst.flags", 64'(bus.Flags),       64'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();
    chk("post.op",  64'(bus.OpCodeIDEXOUT), 64'h3);
    chk("post.opa", 64'(bus.opa_o),         64'd22);
    chk("post.sq",  64'(bus.squashing_o),   64'h0);
    bus.opa_i = 32'd33;
    step();
    chk("post2.opa", 64'(bus.opa_o), 64'd33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
